// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, active window, pixel coordinates and frame strobes
// for an arbitrary geometry, delivered through an enable-gated output pipeline.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 29,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int PIPE     = 1,
   parameter int ANIM_DIV = 1,
   parameter int XW       = 10,
   parameter int YW       = 10,
   parameter int FW       = 8
) (
   input  logic          dclk,
   input  logic          clr,
   input  logic          en,
   output logic          hsync,
   output logic          vsync,
   output logic          active,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic          anim_tick,
   output logic [FW-1:0] frame_cnt
);

   localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int PW = XW + YW + 6;

   if (PIPE < 1 || PIPE > 4 || ANIM_DIV < 1 || ANIM_DIV > 255 ||
       H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       H_ACTIVE < 1 || V_ACTIVE < 1 || HT > (1 << XW) || VT > (1 << YW)) begin : g_param_err
      $error("vga_timing_gen: illegal parameter set");
   end

   localparam logic          HS_ON   = (HS_POL != 0);
   localparam logic          VS_ON   = (VS_POL != 0);
   localparam logic [XW-1:0] H_LAST  = XW'(HT - 1);
   localparam logic [XW-1:0] H_SE    = XW'(H_SYNC);
   localparam logic [XW-1:0] H_AS    = XW'(H_SYNC + H_BP);
   localparam logic [XW-1:0] H_AE    = XW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [YW-1:0] V_LAST  = YW'(VT - 1);
   localparam logic [YW-1:0] V_SE    = YW'(V_SYNC);
   localparam logic [YW-1:0] V_AS    = YW'(V_SYNC + V_BP);
   localparam logic [YW-1:0] V_AE    = YW'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [7:0]    DIV_LAST = 8'(ANIM_DIV - 1);
   localparam logic [PW-1:0] RST_VEC = {~HS_ON, ~VS_ON, {(PW-2){1'b0}}};

   logic [XW-1:0] hc;
   logic [YW-1:0] vc;
   logic [7:0]    div_q;

   logic          raw_hs, raw_vs, raw_act, anim_evt;
   logic [XW-1:0] raw_x;
   logic [YW-1:0] raw_y;
   logic [PW-1:0] raw_p0;
   logic [PW-1:0] load_vec;
   logic [PW-1:0] pipe_p [PIPE];

   always_comb begin
      raw_hs   = (hc < H_SE) ? HS_ON : ~HS_ON;
      raw_vs   = (vc < V_SE) ? VS_ON : ~VS_ON;
      raw_act  = (hc >= H_AS) && (hc < H_AE) && (vc >= V_AS) && (vc < V_AE);
      raw_x    = raw_act ? (hc - H_AS) : '0;
      raw_y    = raw_act ? (vc - V_AS) : '0;
      anim_evt = (hc == '0) && (vc == V_AE);
      raw_p0   = {raw_hs, raw_vs, raw_act, raw_x, raw_y,
                  (hc == '0), (hc == '0) && (vc == '0), anim_evt && (div_q == DIV_LAST)};
   end

   // Value entering the output stage on this edge; drives the frame counter.
   if (PIPE == 1) begin : g_load_raw
      assign load_vec = raw_p0;
   end else begin : g_load_pipe
      assign load_vec = pipe_p[PIPE-2];
   end

   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         hc        <= '0;
         vc        <= '0;
         div_q     <= '0;
         frame_cnt <= '0;
      end else if (en) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + YW'(1);
         end else begin
            hc <= hc + XW'(1);
         end
         if (anim_evt)
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + 8'd1;
         if (load_vec[1])
            frame_cnt <= frame_cnt + FW'(1);
      end
   end

   // Output pipeline: holds on en=0, but the pulse bits of the last stage drop so
   // every strobe is exactly one dclk wide.
   always_ff @(posedge dclk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < PIPE; i++)
            pipe_p[i] <= RST_VEC;
      end else if (en) begin
         pipe_p[0] <= raw_p0;
         for (int i = 1; i < PIPE; i++)
            pipe_p[i] <= pipe_p[i-1];
      end else begin
         pipe_p[PIPE-1][2:0] <= 3'b000;
      end
   end

   assign {hsync, vsync, active, x, y, line_start, frame_start, anim_tick} = pipe_p[PIPE-1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 14x7 raster with PIPE=3, ANIM_DIV=3.
module tb_vga_timing_gen;

   // Hand-derived geometry: HT=3+1+8+2=14, VT=1+1+4+1=7, frame=98 positions.
   localparam int HT = 14;
   localparam int VT = 7;
   localparam int FT = 98;
   localparam int PIPE = 3;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       act;
      logic [3:0] x;
      logic [2:0] y;
      logic       ls;
      logic       fs;
      logic       at;
      logic [7:0] fc;
   } out_t;

   logic       dclk, clr, en;
   logic       hsync, vsync, active, line_start, frame_start, anim_tick;
   logic [3:0] x;
   logic [2:0] y;
   logic [7:0] frame_cnt;

   int   checks = 0;
   int   errors = 0;
   int   n_en = 0;
   bit   pulse_ok = 0;
   int   cyc_no = 0;
   int   cnt_hs, cnt_act, cnt_ls, cnt_fs, cnt_at;
   out_t sb [$];

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(0), .PIPE(PIPE), .ANIM_DIV(3),
      .XW(4), .YW(3), .FW(8)
   ) dut (
      .dclk(dclk), .clr(clr), .en(en),
      .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
      .line_start(line_start), .frame_start(frame_start), .anim_tick(anim_tick),
      .frame_cnt(frame_cnt)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   // Expected outputs after n enabled edges since reset: the output shows raster
   // position k = n-PIPE; pulses only when the last edge was enabled.
   function automatic out_t model(input int n, input bit pulses);
      out_t o;
      int   k, hc, vc;
      o = '0;
      o.hs = 1'b0;
      o.vs = 1'b1;
      if (n < PIPE) return o;
      k  = n - PIPE;
      hc = k % HT;
      vc = (k / HT) % VT;
      o.hs  = (hc < 3);
      o.vs  = !(vc < 1);
      o.act = (hc >= 4) && (hc < 12) && (vc >= 2) && (vc < 6);
      if (o.act) begin
         o.x = 4'(hc - 4);
         o.y = 3'(vc - 2);
      end
      o.fc = 8'((k / FT + 1) % 256);
      if (pulses) begin
         o.ls = (hc == 0);
         o.fs = (hc == 0) && (vc == 0);
         o.at = (hc == 0) && (vc == 6) && (((k / FT) + 1) % 3 == 0);
      end
      return o;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // One dclk cycle of stimulus; pushes the response expected after its rising edge.
   task automatic cyc(input bit e, input bit c);
      @(negedge dclk);
      en  = e;
      clr = c;
      if (c) begin
         n_en = 0;
         pulse_ok = 0;
      end else if (e) begin
         n_en++;
         pulse_ok = 1;
      end else begin
         pulse_ok = 0;
      end
      sb.push_back(model(n_en, pulse_ok));
   endtask

   initial begin : monitor
      out_t got, exp;
      forever begin
         @(posedge dclk);
         #1;
         cyc_no++;
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            got = {hsync, vsync, active, x, y, line_start, frame_start, anim_tick, frame_cnt};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL scoreboard cycle %0d: got hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b at=%b fc=%0d, expected hs=%b vs=%b act=%b x=%0d y=%0d ls=%b fs=%b at=%b fc=%0d",
                        cyc_no, got.hs, got.vs, got.act, got.x, got.y, got.ls, got.fs, got.at, got.fc,
                        exp.hs, exp.vs, exp.act, exp.x, exp.y, exp.ls, exp.fs, exp.at, exp.fc);
            end
            cnt_hs  += int'(hsync);
            cnt_act += int'(active);
            cnt_ls  += int'(line_start);
            cnt_fs  += int'(frame_start);
            cnt_at  += int'(anim_tick);
         end
      end
   end

   initial begin : driver
      clr = 1'b0;
      en  = 1'b0;
      #1 clr = 1'b1;
      #1;
      chk("reset_hsync", int'(hsync), 0);
      chk("reset_vsync", int'(vsync), 1);
      chk("reset_active", int'(active), 0);
      chk("reset_xy", int'({x, y}), 0);
      chk("reset_frame_cnt", int'(frame_cnt), 0);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b1);

      // Nine full frames with en held high.
      cnt_hs = 0; cnt_act = 0; cnt_ls = 0; cnt_fs = 0; cnt_at = 0;
      for (int i = 0; i < 884; i++) cyc(1'b1, 1'b0);
      @(posedge dclk);
      #2;
      chk("hsync_high_cycles", cnt_hs, 189);
      chk("active_cycles", cnt_act, 288);
      chk("line_starts", cnt_ls, 63);
      chk("frame_starts", cnt_fs, 9);
      chk("anim_ticks", cnt_at, 3);
      chk("frame_cnt_9", int'(frame_cnt), 9);

      // en pattern 1,0,0,1: two frames take twice as many dclk cycles.
      cnt_fs = 0; cnt_at = 0;
      for (int i = 0; i < 392; i++) cyc((i % 4 == 0) || (i % 4 == 3), 1'b0);
      @(posedge dclk);
      #2;
      chk("frame_starts_gated", cnt_fs, 2);
      chk("frame_cnt_11", int'(frame_cnt), 11);

      // Advance to x=5 of the first active line, then reset mid-line.
      for (int i = 0; i < 38; i++) cyc(1'b1, 1'b0);
      @(posedge dclk);
      #2;
      chk("midline_active", int'(active), 1);
      chk("midline_x", int'(x), 5);
      chk("midline_frame_cnt", int'(frame_cnt), 12);
      cyc(1'b1, 1'b1);
      #1;
      chk("clr_immediate_active", int'(active), 0);
      chk("clr_immediate_x", int'(x), 0);
      chk("clr_immediate_hsync", int'(hsync), 0);
      chk("clr_immediate_frame_cnt", int'(frame_cnt), 0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
      @(posedge dclk);
      #2;
      chk("restart_frame_start", int'(frame_start), 1);
      chk("restart_line_start", int'(line_start), 1);
      chk("restart_frame_cnt", int'(frame_cnt), 1);

      // Hold with en low, then resume.
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
      @(posedge dclk);
      #2;
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync counter.
- Generates hsync/vsync, the active-video flag and zero-based pixel coordinates for any raster geometry, with a programmable sync polarity and a programmable output pipeline latency so coordinates line up with downstream renderer stages.
- Also produces line/frame strobes, a frame counter and a frame-divided animation tick issued in vertical blanking; this replaces the ad-hoc animateClk edge-detect used by the renderers.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 29, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level (0 = active-low)
PIPE, 1, output latency in enabled cycles, legal 1..4
ANIM_DIV, 1, frames per anim_tick, legal 1..255
XW, 10, width of x and of the internal hc counter
YW, 10, width of y and of the internal vc counter
FW, 8, frame_cnt width

Ports:
dclk  in  1  pixel clock
clr  in  1  asynchronous reset, active-high
en  in  1  pixel enable; the block advances only on dclk edges with en=1
hsync  out  1  horizontal sync, asserted level HS_POL
vsync  out  1  vertical sync, asserted level VS_POL
active  out  1  pixel is inside the visible window
x  out  XW  visible column 0..H_ACTIVE-1; 0 when active=0
y  out  YW  visible row 0..V_ACTIVE-1; 0 when active=0
line_start  out  1  one-cycle pulse at hc=0
frame_start  out  1  one-cycle pulse at hc=0, vc=0
anim_tick  out  1  one-cycle pulse at first blanking line, every ANIM_DIV frames
frame_cnt  out  FW  frames completed, wraps modulo 2^FW

Behaviour:
- Line order per line: sync, back porch, active, front porch.
  - HT = H_SYNC+H_BP+H_ACTIVE+H_FP (800 at default); VT likewise (521).
- Counters (hc, vc), on en=1:
  - hc increments 0..HT-1, then wraps to 0.
  - vc increments when hc wraps; vc wraps VT-1 -> 0.
- Raw per-position values:
  - hsync asserted for hc < H_SYNC; vsync asserted for vc < V_SYNC.
  - active = (H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE) and the same test on vc with the vertical parameters.
  - x = hc-(H_SYNC+H_BP) and y = vc-(V_SYNC+V_BP) when active, else 0.
- Pipeline:
  - Raw values pass through a PIPE-deep register chain that advances only on en=1.
  - All outputs are aligned: the output reflects the hc/vc value held PIPE enabled cycles earlier.
- Pulses (line_start, frame_start, anim_tick):
  - High for exactly one dclk cycle, the cycle after the enabled edge that loads them into the output stage.
  - Forced 0 while en=0, even though the pipeline holds.
- frame_cnt increments in the same cycle frame_start asserts. It is 0 before the first frame_start output; first output frame_start gives frame_cnt=1.
- anim_tick:
  - Internal divider counts 0..ANIM_DIV-1, advancing on each raw event (hc=0, vc=V_SYNC+V_BP+V_ACTIVE).
  - anim_tick asserts when the divider wraps to 0.
  - With ANIM_DIV=1 it fires every frame. The first tick occurs on the ANIM_DIV-th such line after reset.
- Reset (async, clr=1, any time including mid-line):
  - hc, vc, divider and all pipeline stages cleared.
  - hsync=~HS_POL, vsync=~VS_POL, active=0, x=0, y=0, all pulses 0, frame_cnt=0.
  - After clr deasserts, the hc=0/vc=0 position reaches the outputs on the PIPE-th enabled edge. The first frame_start appears then.
- en held low: counters, divider, frame_cnt and level outputs hold their values indefinitely; no pulse is emitted.
- Simultaneous events:
  - At hc=0, vc=0, line_start and frame_start assert together.
  - anim_tick never coincides with frame_start, since it occurs in a blanking line.
- Illegal parameters (PIPE outside 1..4, ANIM_DIV=0, any porch or sync = 0, HT > 2^XW) are a build-time error.

Test Plan:
1. Defaults, en=1 for 2 frames. Expect hsync low exactly 96 cycles, period 800; vsync low 1600 cycles, period 416800; 640x480=307200 active cycles per frame.
2. Defaults, PIPE=1. Expect active rising one cycle after hc=144 with x=0; x=639 at the last active cycle; first active line has y=0 at vc=31, last y=479 at vc=510.
3. H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, PIPE=3, HS_POL=1. Expect HT=14, hsync high 3 cycles, outputs delayed 3 cycles versus PIPE=1, and all outputs stay aligned.
4. Small config, ANIM_DIV=3, 9 frames. Expect 3 anim_ticks, each at hc=0 of line 6 (delayed by PIPE), each 1 dclk wide; frame_cnt reaches 9.
5. en toggling 1,0,0,1 repeatedly. Expect the raster period to double in dclk cycles, pulses still exactly 1 dclk wide, and no output change on en=0 cycles.
6. Assert clr mid-active-line (x=100) for 1 cycle. Expect outputs to return to reset values immediately, the next frame_start on the PIPE-th enabled edge after release, and frame_cnt to restart from 1.
